// File: rtl/mac_datapath_pkg.sv
// Shared widths, controller state encodings and the strobe bundle for the MAC datapath.
package mac_datapath_pkg;

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   function automatic int sum_width(input int w);
      return 2 * w + 1;
   endfunction

   localparam int DEF_W  = 8;
   localparam int PROD_W = prod_width(DEF_W);
   localparam int SUM_W  = sum_width(DEF_W);

   // Sequencing controller encoding: idle, load, compute, accumulate, publish.
   localparam logic [2:0] S0 = 3'b000;
   localparam logic [2:0] S1 = 3'b001;
   localparam logic [2:0] S2 = 3'b010;
   localparam logic [2:0] S3 = 3'b011;
   localparam logic [2:0] S4 = 3'b100;

   typedef struct packed {
      logic sel1;
      logic sel2;
      logic sel3;
      logic sel4;
      logic mux1;
      logic mux2;
      logic aout;
   } strobe_t;

endpackage

// File: rtl/mac_datapath_sat_add.sv
// Unsigned adder with carry out; clamps to all-ones on overflow when SATURATE_EN is defined.
module sat_add #(
   parameter int WD = 16
) (
   input  logic [WD-1:0] a,
   input  logic [WD-1:0] b,
   output logic [WD-1:0] sum,
   output logic          carry
);

   logic [WD:0] full;

   assign full  = {1'b0, a} + {1'b0, b};
   assign carry = full[WD];

`ifdef SATURATE_EN
   assign sum = carry ? {WD{1'b1}} : full[WD-1:0];
`else
   assign sum = full[WD-1:0];
`endif

endmodule

// File: rtl/mac_datapath.sv
// Operand/product/sum datapath driven by the five-state controller's strobes.
// Optional build macro SATURATE_EN makes overflowing PROD/SUM updates clamp instead of wrap.
module mac_datapath
   import mac_datapath_pkg::*;
#(
   parameter int W            = 8,
   parameter int CW           = 4,
   parameter bit AUTO_CAPTURE = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    din_a,
   input  logic [W-1:0]    din_b,
   input  logic            sel1,
   input  logic            sel3,
   input  logic            sel2,
   input  logic            mux1,
   input  logic            sel4,
   input  logic            mux2,
   input  logic            Aout,
   output logic [2*W:0]    dout,
   output logic            dout_valid,
   output logic            ovf,
   output logic [CW-1:0]   result_cnt
);

   localparam int PW = prod_width(W);
   localparam int SW = sum_width(W);

   strobe_t        st;
   logic [W-1:0]   ra, rb;
   logic [PW-1:0]  prod;
   logic [SW-1:0]  sum;
   logic           cap_pend;

   logic [PW-1:0]  prod_mul;
   logic [PW-1:0]  prod_acc;
   logic           prod_c;
   logic [SW-1:0]  sum_ab;
   logic [SW-1:0]  sum_acc;
   logic           sum_c;
   logic           publish;

   assign st = '{sel1: sel1, sel2: sel2, sel3: sel3, sel4: sel4,
                 mux1: mux1, mux2: mux2, aout: Aout};

   // Operands are zero-extended to the destination width, so neither of these can overflow.
   assign prod_mul = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
   assign sum_ab   = {{(W+1){1'b0}}, ra} + {{(W+1){1'b0}}, rb};

   sat_add #(.WD(PW)) u_prod_add (
      .a     (prod),
      .b     ({{W{1'b0}}, ra}),
      .sum   (prod_acc),
      .carry (prod_c)
   );

   sat_add #(.WD(SW)) u_sum_add (
      .a     (sum),
      .b     ({1'b0, prod}),
      .sum   (sum_acc),
      .carry (sum_c)
   );

   // A pending auto-capture and an explicit Aout in the same cycle merge into one publish.
   assign publish = cap_pend | st.aout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ra         <= '0;
         rb         <= '0;
         prod       <= '0;
         sum        <= '0;
         ovf        <= 1'b0;
         cap_pend   <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         result_cnt <= '0;
      end else begin
         if (st.sel1) ra <= din_a;
         if (st.sel3) rb <= din_b;

         if (st.sel2) begin
            prod <= st.mux1 ? prod_acc : prod_mul;
            if (st.mux1 && prod_c) ovf <= 1'b1;
         end

         if (st.sel4) begin
            sum <= st.mux2 ? sum_acc : sum_ab;
            if (st.mux2 && sum_c) ovf <= 1'b1;
         end

         cap_pend <= AUTO_CAPTURE & st.sel4 & st.mux2;

         // dout takes the SUM register as it stands before this edge.
         dout_valid <= publish;
         if (publish) begin
            dout       <= sum;
            result_cnt <= result_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_datapath.sv
// Directed-vector bench for mac_datapath: one auto-capture instance and one Aout-only instance.
module tb_mac_datapath;
   import mac_datapath_pkg::*;

   localparam int W  = 8;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [W-1:0]    din_a, din_b;
   logic            sel1, sel2, sel3, sel4, mux1, mux2, aout;

   logic [2*W:0]    dout, dout0;
   logic            dout_valid, dout_valid0;
   logic            ovf, ovf0;
   logic [CW-1:0]   result_cnt, result_cnt0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_datapath #(.W(W), .CW(CW), .AUTO_CAPTURE(1'b1)) dut (
      .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b),
      .sel1(sel1), .sel3(sel3), .sel2(sel2), .mux1(mux1),
      .sel4(sel4), .mux2(mux2), .Aout(aout),
      .dout(dout), .dout_valid(dout_valid), .ovf(ovf), .result_cnt(result_cnt)
   );

   mac_datapath #(.W(W), .CW(CW), .AUTO_CAPTURE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b),
      .sel1(sel1), .sel3(sel3), .sel2(sel2), .mux1(mux1),
      .sel4(sel4), .mux2(mux2), .Aout(aout),
      .dout(dout0), .dout_valid(dout_valid0), .ovf(ovf0), .result_cnt(result_cnt0)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one strobe vector, clock it in, then settle past the edge.
   task automatic cyc(input logic s1, input logic s2, input logic s3, input logic s4,
                      input logic m1, input logic m2, input logic ao);
      sel1 = s1; sel2 = s2; sel3 = s3; sel4 = s4;
      mux1 = m1; mux2 = m2; aout = ao;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [2:0] st_seq;
      rst = 1'b0; din_a = '0; din_b = '0;
      idle();
      idle();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_cnt", result_cnt, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cnt0", result_cnt0, 0);
      rst = 1'b1;

      // Full controller walk: S1 load, S2 compute, S3 accumulate, S4 publish.
      st_seq = S1;
      din_a = 8'd3; din_b = 8'd5;
      cyc(1, 0, 1, 0, 0, 0, 0);
      chk("s1_ra", dut.ra, 3);
      chk("s1_rb", dut.rb, 5);
      st_seq = S2;
      cyc(0, 1, 0, 1, 0, 0, 0);
      chk("s2_prod", dut.prod, 15);
      chk("s2_sum", dut.sum, 8);
      st_seq = S3;
      cyc(0, 1, 0, 1, 1, 1, 0);
      chk("s3_prod", dut.prod, 18);
      chk("s3_sum", dut.sum, 23);
      chk("s3_novalid", dout_valid, 0);
      st_seq = S4;
      idle();
      chk("s4_dout", dout, 23);
      chk("s4_valid", dout_valid, 1);
      chk("s4_cnt", result_cnt, 1);
      chk("s4_ovf", ovf, 0);
      chk("s4_auto0_novalid", dout_valid0, 0);
      chk("s4_auto0_cnt", result_cnt0, 0);
      st_seq = S0;
      idle();
      chk("pulse_one_cycle", dout_valid, 0);
      chk("dout_hold", dout, 23);
      chk("state_idle", st_seq, 0);

      // Aout alone on the Aout-only instance publishes the current SUM.
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("aout_dout0", dout0, 23);
      chk("aout_valid0", dout_valid0, 1);
      chk("aout_cnt0", result_cnt0, 1);
      chk("aout_cnt", result_cnt, 2);
      idle();

      // cap_pend and Aout together: one publish, one increment.
      cyc(0, 0, 0, 1, 0, 1, 0);
      chk("acc2_sum", dut.sum, 41);
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("coin_dout", dout, 41);
      chk("coin_cnt", result_cnt, 3);
      chk("coin_cnt0", result_cnt0, 2);
      idle();
      chk("coin_after_valid", dout_valid, 0);
      chk("coin_after_cnt", result_cnt, 3);

      // sel1 together with a multiply uses the old RA.
      din_a = 8'd4; din_b = 8'd2;
      cyc(1, 0, 1, 0, 0, 0, 0);
      din_a = 8'd9;
      cyc(1, 1, 0, 0, 0, 0, 0);
      chk("same_prod", dut.prod, 8);
      chk("same_ra", dut.ra, 9);

      // Overflow of SUM through repeated accumulation.
      din_a = 8'd255; din_b = 8'd255;
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0, 0);
      chk("ov_prod", dut.prod, 65025);
      chk("ov_sum", dut.sum, 510);
      cyc(0, 0, 0, 1, 0, 1, 0);
      chk("ov_acc1", dut.sum, 65535);
      chk("ov_ovf1", ovf, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
      chk("ov_acc2", dut.sum, 130560);
      chk("ov_ovf2", ovf, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
`ifdef SATURATE_EN
      chk("ov_acc3", dut.sum, 131071);
`else
      chk("ov_acc3", dut.sum, 64513);
`endif
      chk("ov_ovf3", ovf, 1);
      idle();
      idle();
      chk("ov_sticky", ovf, 1);

      // Reset during the accumulate cycle discards everything.
      din_a = 8'd3; din_b = 8'd5;
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0, 0);
      rst = 1'b0;
      cyc(0, 1, 0, 1, 1, 1, 0);
      chk("mid_ra", dut.ra, 0);
      chk("mid_prod", dut.prod, 0);
      chk("mid_sum", dut.sum, 0);
      chk("mid_dout", dout, 0);
      chk("mid_ovf", ovf, 0);
      chk("mid_cnt", result_cnt, 0);
      chk("mid_valid", dout_valid, 0);
      rst = 1'b1;
      idle();
      chk("mid_no_pulse", dout_valid, 0);

      // 16 back-to-back publishes wrap the 4-bit counter.
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         if (i == 15) chk("wrap_15", result_cnt, 15);
         if (i == 16) chk("wrap_0", result_cnt, 0);
      end
      chk("wrap_valid", dout_valid, 1);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_datapath.md
Name: mac_datapath

Overview:
Arithmetic datapath driven by the five-state sequencing controller's strobes (sel1..sel4, mux1, mux2, Aout).
- Registers two operands and forms their product and sum.
- Accumulates the product into the sum and publishes a registered result with a one-cycle valid pulse.
- Samples all control inputs synchronously on clk. Controller output delays are irrelevant as long as controls settle before the next edge.

Parameters:
W, 8, operand width (unsigned)
CW, 4, width of result counter
AUTO_CAPTURE, 1, 1: publish result one cycle after a sel4&mux2 update; 0: publish only on Aout

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
din_a  input  W  operand A source
din_b  input  W  operand B source
sel1  input  1  load RA <= din_a
sel3  input  1  load RB <= din_b
sel2  input  1  enable PROD update
mux1  input  1  PROD source: 0 = RA*RB, 1 = PROD+RA
sel4  input  1  enable SUM update
mux2  input  1  SUM source: 0 = RA+RB, 1 = SUM+PROD
Aout  input  1  explicit publish strobe
dout  output  2W+1  published result
dout_valid  output  1  one-cycle pulse when dout updates
ovf  output  1  sticky overflow flag
result_cnt  output  CW  count of publishes, wraps

Behaviour:
- Reset (rst=0 at a clk edge): RA, RB, PROD, SUM, dout, ovf, result_cnt, cap_pend and dout_valid all go to 0. Reset has priority over every strobe and is honoured mid-sequence; the partial result is discarded.
- Internal widths: RA and RB are W bits. PROD is 2W bits. SUM is 2W+1 bits. All arithmetic is unsigned.
- Register updates on each edge (nonblocking semantics; every right-hand side uses pre-edge values):
  - sel1: RA <= din_a.
  - sel3: RB <= din_b.
  - sel2 & !mux1: PROD <= RA*RB.
  - sel2 & mux1: PROD <= PROD+RA, truncated to 2W bits, with ovf set on carry out.
  - sel4 & !mux2: SUM <= RA+RB.
  - sel4 & mux2: SUM <= SUM+PROD; carry out of bit 2W sets ovf and the result wraps modulo 2^(2W+1).
- Same-cycle strobes: sel1 with sel2 or sel4 means the arithmetic uses the old RA; the new RA is visible next cycle.
- Capture pipeline:
  - cap_pend <= AUTO_CAPTURE & sel4 & mux2.
  - A publish occurs on an edge where (cap_pend | Aout) is 1. On a publish: dout <= SUM (already-updated value); dout_valid <= 1; result_cnt <= result_cnt+1, wrapping at 2^CW.
  - Otherwise dout holds and dout_valid <= 0.
  - cap_pend and Aout in the same cycle produce a single publish and a single increment.
- Latency: with AUTO_CAPTURE=1, dout/dout_valid appear one cycle after the SUM+PROD update edge. Full controller sequence: s1 load, s2 compute, s3 accumulate, s4 publish.
- ovf is cleared only by reset.
- Strobes all 0: every register holds.

Optional Feature:
SATURATE_EN
- Defined: any overflowing PROD or SUM update clamps to all-ones of that register's width; ovf is still set.
- Undefined: overflowing updates wrap modulo the register width and set ovf.

Decomposition:
- Shared package holds:
  - width-derivation constants: PROD_W = 2W, SUM_W = 2W+1.
  - controller state encoding constants s0..s4 (3'b000..3'b100), for bench and assertions.
  - strobe-bundle struct typedef {sel1, sel2, sel3, sel4, mux1, mux2, Aout}.
- One natural sub-module: sat_add. Parametric-width adder producing sum and carry; saturates under SATURATE_EN. Instantiated for both PROD and SUM.

Test Plan:
- Full controller sequence, W=8, din_a=3, din_b=5, AUTO_CAPTURE=1 -> after s1 RA=3, RB=5; after s2 PROD=15, SUM=8; after s3 PROD=18, SUM=23; next edge dout=23, dout_valid=1 for exactly one cycle, result_cnt=1, ovf=0.
- Overflow: from SUM=510 and PROD=65025, hold sel4=mux2=1 for 3 cycles -> SUM=65535, then 130560, then 64513 with ovf=1. With SATURATE_EN: third value 131071, ovf=1.
- Reset mid-op: assert rst=0 during the s3 cycle -> next edge all registers 0, no dout_valid pulse, result_cnt=0.
- Aout and cap_pend coincide -> one publish, result_cnt increments by 1 only. Aout alone with AUTO_CAPTURE=0 -> publishes current SUM.
- sel1 asserted with sel2&!mux1, RA old=4, RB=2, din_a=9 -> PROD=8, RA=9.
- 16 consecutive publishes with CW=4 -> result_cnt wraps to 0.
